// File: rtl/inv_shift_row_serial_pkg.sv
// Shared AES constants and the row-shift index helpers used by the
// byte-serial InvShiftRows and ShiftRows stages.
package inv_shift_row_serial_pkg;

    localparam int STATE_BYTES = 16;
    localparam int NUM_ROWS    = 4;

    localparam logic [3:0] LAST_IDX = 4'(STATE_BYTES - 1);

    typedef logic [3:0]                    byte_idx_t;
    typedef logic [$clog2(NUM_ROWS)-1:0]   rc_idx_t;

    // Source index for output byte dst_idx of InvShiftRows:
    // out[r][c] = in[r][(c - r) mod 4]; row-major byte k = 4r + c.
    function automatic byte_idx_t inv_sr_src_idx(input byte_idx_t dst_idx);
        rc_idx_t row;
        rc_idx_t col;
        row = dst_idx[3:2];
        col = dst_idx[1:0] - row;
        return {row, col};
    endfunction

    // Forward form used by the encrypt-side ShiftRows stage:
    // out[r][c] = in[r][(c + r) mod 4].
    function automatic byte_idx_t fwd_sr_src_idx(input byte_idx_t dst_idx);
        rc_idx_t row;
        rc_idx_t col;
        row = dst_idx[3:2];
        col = dst_idx[1:0] + row;
        return {row, col};
    endfunction

endpackage

// File: rtl/inv_shift_row_serial_if.sv
// Byte-stream interface of the serial InvShiftRows stage: upstream byte
// input, downstream byte output, and the optional parallel state output
// (present only when INV_SR_PAR_OUT_EN is defined).
interface inv_shift_row_serial_if;

    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
`ifdef INV_SR_PAR_OUT_EN
    logic [127:0] out_state;
    logic         out_state_valid;
`endif

`ifdef INV_SR_PAR_OUT_EN
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_state, out_state_valid
    );
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, out_state, out_state_valid
    );
`else
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
`endif

endinterface

// File: rtl/inv_shift_row_map.sv
// Combinational InvShiftRows index map: output byte index -> source byte
// index within the stored (arrival-order) state.
module inv_shift_row_map
    import inv_shift_row_serial_pkg::*;
(
    input  logic [3:0] dst_idx,
    output logic [3:0] src_idx
);

    assign src_idx = inv_sr_src_idx(dst_idx);

endmodule

// File: rtl/inv_shift_row_serial.sv
// Byte-serial AES InvShiftRows with two ping-pong state banks so one state
// fills while the other drains at one byte per cycle.
// Optional feature macro: INV_SR_PAR_OUT_EN adds a one-cycle parallel
// 128-bit inverse-shifted state output when a bank becomes full.
module inv_shift_row_serial
    import inv_shift_row_serial_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    inv_shift_row_serial_if.slave bus
);

    // Bank data is deliberately not reset; the full flags gate its use.
    logic [7:0] bank_reg [2][STATE_BYTES];

    logic [1:0] full_reg;
    logic [1:0] full_next;
    logic       wb_reg;
    logic       rb_reg;
    logic [3:0] wc_reg;
    logic [3:0] rc_reg;

    logic       in_ready_int;
    logic       out_valid_int;
    logic       wr_fire;
    logic       rd_fire;
    logic       wr_done;
    logic       rd_done;
    logic [3:0] rd_idx;

    // Handshakes depend only on registered flags, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready_int  = !full_reg[wb_reg];
    assign out_valid_int = full_reg[rb_reg];
    assign wr_fire       = bus.in_valid && in_ready_int;
    assign rd_fire       = out_valid_int && bus.out_ready;
    assign wr_done       = wr_fire && (wc_reg == LAST_IDX);
    assign rd_done       = rd_fire && (rc_reg == LAST_IDX);

    inv_shift_row_map u_rd_map (
        .dst_idx (rc_reg),
        .src_idx (rd_idx)
    );

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.out_last  = out_valid_int && (rc_reg == LAST_IDX);
    assign bus.out_data  = bank_reg[rb_reg][rd_idx];

    // Set the filling bank's flag and clear the draining bank's flag; when
    // both happen in one cycle they always address different banks.
    always_comb begin
        full_next = full_reg;
        if (wr_done) begin
            full_next[wb_reg] = 1'b1;
        end
        if (rd_done) begin
            full_next[rb_reg] = 1'b0;
        end
    end

    // Bank flags and write/read pointers; reset discards partial states.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_reg <= 2'b00;
            wb_reg   <= 1'b0;
            rb_reg   <= 1'b0;
            wc_reg   <= 4'd0;
            rc_reg   <= 4'd0;
        end else begin
            full_reg <= full_next;
            if (wr_fire) begin
                wc_reg <= wr_done ? 4'd0 : wc_reg + 4'd1;
                if (wr_done) begin
                    wb_reg <= ~wb_reg;
                end
            end
            if (rd_fire) begin
                rc_reg <= rd_done ? 4'd0 : rc_reg + 4'd1;
                if (rd_done) begin
                    rb_reg <= ~rb_reg;
                end
            end
        end
    end

    // Store incoming bytes in arrival order into the bank being filled.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            bank_reg[wb_reg][wc_reg] <= bus.in_data;
        end
    end

`ifdef INV_SR_PAR_OUT_EN
    logic       par_valid_reg;
    logic       par_bank_reg;
    logic [3:0] par_src [STATE_BYTES];

    // Pulse in the cycle a bank's full flag rises and remember which bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_valid_reg <= 1'b0;
            par_bank_reg  <= 1'b0;
        end else begin
            par_valid_reg <= wr_done;
            if (wr_done) begin
                par_bank_reg <= wb_reg;
            end
        end
    end

    genvar gi;
    for (gi = 0; gi < STATE_BYTES; gi = gi + 1) begin : g_par
        inv_shift_row_map u_par_map (
            .dst_idx (4'(gi)),
            .src_idx (par_src[gi])
        );
        assign bus.out_state[127 - 8*gi -: 8] = bank_reg[par_bank_reg][par_src[gi]];
    end

    assign bus.out_state_valid = par_valid_reg;
`endif

endmodule

// File: tb/tb_inv_shift_row_serial.sv
// Self-checking bench for inv_shift_row_serial: a queue-based model of the
// byte stream is compared against the DUT on every cycle, plus literal
// expectations for the reference sequences. Works with or without
// INV_SR_PAR_OUT_EN.
module tb_inv_shift_row_serial;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    inv_shift_row_serial_if bus ();

    inv_shift_row_serial dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [7:0]   in_buf[$];
    logic [7:0]   exp_q[$];
    logic [127:0] sent_q[$];
    logic [7:0]   got_buf[$];
    bit           in_fire  = 1'b0;
    bit           out_fire = 1'b0;
    int           last_in_cyc  = 0;
    int           first_ov_cyc = -1;
    int           stall_cnt    = 0;
    logic [7:0]   log_data[$];
    int           log_cyc[$];
    bit           log_last[$];
    bit           par_exp = 1'b0;
    logic [127:0] par_val = '0;
    bit           rand_done;

    logic [7:0] exp_a [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h04, 8'h05, 8'h06,
                               8'h0A, 8'h0B, 8'h08, 8'h09, 8'h0D, 8'h0E, 8'h0F, 8'h0C};
    logic [7:0] exp_d [16] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h17, 8'h14, 8'h15, 8'h16,
                               8'h1A, 8'h1B, 8'h18, 8'h19, 8'h1D, 8'h1E, 8'h1F, 8'h1C};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Pack 16 bytes row-major: byte k at bits [127-8k -: 8].
    function automatic logic [127:0] pack16(input logic [7:0] b [16]);
        logic [127:0] s;
        for (int k = 0; k < 16; k++) s[127 - 8*k -: 8] = b[k];
        return s;
    endfunction

    // Per-cycle compare and model update, sampled mid-cycle.
    always @(negedge clk) begin
        logic [7:0] src [16];
        logic [7:0] dst [16];
        int         pend;
        cyc++;
        pend = (exp_q.size() + 15) / 16;
        check("in_ready",  bus.in_ready,  pend < 2);
        check("out_valid", bus.out_valid, exp_q.size() > 0);
        check("out_last",  bus.out_last,  (exp_q.size() % 16) == 1);
        if (exp_q.size() > 0) check("out_data", bus.out_data, exp_q[0]);
`ifdef INV_SR_PAR_OUT_EN
        check("out_state_valid", bus.out_state_valid, par_exp);
        if (par_exp) check("out_state", bus.out_state, par_val);
`endif
        in_fire  = bus.in_valid && bus.in_ready && !rst;
        out_fire = bus.out_valid && bus.out_ready && !rst;
        par_exp  = 1'b0;
        if (rst) begin
            in_buf.delete();
            exp_q.delete();
            sent_q.delete();
            got_buf.delete();
        end else begin
            if (bus.in_valid && !bus.in_ready) stall_cnt++;
            if (bus.out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
            if (out_fire && exp_q.size() > 0) begin
                log_data.push_back(exp_q[0]);
                log_cyc.push_back(cyc);
                log_last.push_back((exp_q.size() % 16) == 1);
                got_buf.push_back(bus.out_data);
                void'(exp_q.pop_front());
                if (got_buf.size() == 16) begin
                    // Re-apply the encrypt-side shift: must restore the input.
                    for (int r = 0; r < 4; r++)
                        for (int c = 0; c < 4; c++)
                            dst[4*r + c] = got_buf[4*r + (c + r) % 4];
                    if (sent_q.size() > 0) check("roundtrip", pack16(dst), sent_q.pop_front());
                    got_buf.delete();
                end
            end
            if (in_fire) begin
                in_buf.push_back(bus.in_data);
                last_in_cyc = cyc;
                if (in_buf.size() == 16) begin
                    for (int k = 0; k < 16; k++) src[k] = in_buf[k];
                    for (int r = 0; r < 4; r++)
                        for (int c = 0; c < 4; c++)
                            dst[4*r + c] = src[4*r + (c - r + 4) % 4];
                    for (int k = 0; k < 16; k++) exp_q.push_back(dst[k]);
                    sent_q.push_back(pack16(src));
                    par_exp = 1'b1;
                    par_val = pack16(dst);
                    in_buf.delete();
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        do begin
            @(posedge clk); #1;
            t++;
        end while (!in_fire && t < 200);
        if (!in_fire) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: byte %0h not accepted, required within 200 cycles", d);
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() > 0) && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        vectors++;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d bytes left, required 0", exp_q.size());
        end
    endtask

    task automatic clear_log();
        log_data.delete();
        log_cyc.delete();
        log_last.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready",  bus.in_ready,  1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_last",  bus.out_last,  1'b0);
`ifdef INV_SR_PAR_OUT_EN
        check("rst_out_state_valid", bus.out_state_valid, 1'b0);
`endif
        @(posedge clk); #1;

        // Reference sequence 0x00..0x0F
        clear_log();
        first_ov_cyc = -1;
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        bus.in_valid = 1'b0;
`ifdef INV_SR_PAR_OUT_EN
        check("par_valid_lit", bus.out_state_valid, 1'b1);
        check("par_state_lit", bus.out_state, 128'h00010203_07040506_0A0B0809_0D0E0F0C);
        @(posedge clk); #1;
        check("par_valid_one_cycle", bus.out_state_valid, 1'b0);
`endif
        wait_drain();
        check("a_count", log_data.size(), 16);
        for (int i = 0; i < 16 && i < log_data.size(); i++) begin
            check("a_data_lit", log_data[i], exp_a[i]);
            check("a_last_lit", log_last[i], i == 15);
        end
        check("a_latency", first_ov_cyc - last_in_cyc, 1);

        // Three back-to-back states, no bubbles
        clear_log();
        stall_cnt = 0;
        for (int i = 0; i < 48; i++) send_byte(8'($urandom));
        bus.in_valid = 1'b0;
        wait_drain();
        check("b_count", log_data.size(), 48);
        if (log_cyc.size() == 48) check("b_continuous", log_cyc[47] - log_cyc[0], 47);
        check("b_no_stall", stall_cnt, 0);

        // Backpressure: two states fill both banks
        bus.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) send_byte(8'($urandom));
        bus.in_valid = 1'b0;
        check("c_ready_low_full", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            check("c_ready_return", bus.in_ready, i == 17);
        end
        @(posedge clk); #1;
        wait_drain();

        // Reset in the middle of a state
        clear_log();
        for (int i = 0; i < 7; i++) send_byte(8'hA0 + 8'(i));
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
        bus.in_valid = 1'b0;
        wait_drain();
        check("d_count", log_data.size(), 16);
        for (int i = 0; i < 16 && i < log_data.size(); i++)
            check("d_data_lit", log_data[i], exp_d[i]);

        // Random states with random gaps and backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 160; i++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                    send_byte(8'($urandom));
                end
                bus.in_valid = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_drain();
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
